q_path_follower: RTL and testbench
==================================

# q_path_follower

Greedy policy reader for the 6x6 grid Q-learner. It consumes the Q-table after the blocked-state mask has zeroed every action that leads into a blocked cell. From a given start cell it walks the grid, choosing the highest-valued legal action at each cell, and streams each step out over a valid/ready handshake until the goal is reached or the walk fails. It sits downstream of the masking stage and drives the path display and motor-command logic.

## Interface
- Q_W, 32, width of each Q value (unsigned)
- MAX_STEPS, 36, maximum steps emitted before the walk is declared failed
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- q_table  in  [Q_W-1:0] x [37][4]  Q-table indexed [state][action]; state 1..36, index 0 unused; action 0=N, 1=E, 2=S, 3=W
- start_state  in  6  first cell of the walk
- goal_state  in  6  target cell
- start  in  1  one-cycle request to begin a walk
- step_ready  in  1  downstream accepts the current step
- step_valid  out  1  a step is presented
- step_state  out  6  cell the step leaves from
- step_dir  out  2  chosen action
- step_next  out  6  cell the step arrives at
- step_count  out  8  steps accepted in the current or last walk
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse, goal reached
- fail  out  1  one-cycle pulse, walk aborted

## Operation
- Geometry: row r (1..6) holds cells 6(r-1)+1..6r. N = s+6, S = s-6, E = s+1, W = s-1.
- Legal actions: no N from cells 31..36, no S from cells 1..6, no E when s mod 6 = 0, no W when s mod 6 = 1.
- A Q value of 0 marks an action as unusable (masked). A candidate is any legal action with Q > 0.
- Choice: the candidate with the largest unsigned Q. Ties go to the lowest action index (N > E > S > W).
- FSM states: IDLE, EVAL, EMIT, DONE, FAIL.
  - IDLE: start=1 latches start_state, goal_state into cur and goal, clears step_count, goes to EVAL. start is ignored in every other state.
  - EVAL:
    - If cur not in 1..36 or goal not in 1..36: FAIL.
    - Else if cur == goal: DONE.
    - Else if step_count == MAX_STEPS: FAIL.
    - Else if there is no candidate: FAIL.
    - Else register the choice and go to EMIT.
  - EMIT: step_valid=1. On step_valid & step_ready: cur <= step_next, step_count += 1, go to EVAL.
  - DONE and FAIL: assert their pulse for one cycle, then go to IDLE.
- q_table is read combinationally in EVAL. Upstream must hold it stable while busy=1.
- step_count saturates at 255 and is held in IDLE until the next start.

## Timing
- Reset values: step_valid=0, step_state=0, step_dir=0, step_next=0, step_count=0, busy=0, done=0, fail=0, FSM in IDLE.
- Reset has priority over every other event. Asserting rst mid-walk returns all outputs to their reset values at that edge; no pulse is generated.
- start sampled at edge k: busy=1 and the FSM is in EVAL after edge k; step_valid=1 after edge k+1.
- step_state, step_dir and step_next stay stable while step_valid=1 and step_ready=0.
- Throughput is at most one step per 2 cycles (EMIT then EVAL).
- After the accepting edge with step_next == goal: EVAL follows, then DONE. done=1 for one cycle; busy falls with it, in the cycle after DONE.
- start_state == goal_state: done pulses 2 cycles after start with no step emitted; step_count=0.
- busy=1 from EVAL through DONE/FAIL inclusive.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 -> every output 0, no walk begins.
- Simple path: all Q=1 except Q[1][1]=5 and Q[2][0]=5; start 1, goal 8 -> steps (1,E,2) then (2,N,8); done pulses; step_count=2.
- Tie-break and edges: all Q=7; start 1, goal 36 -> N steps 1→7→13→19→25→31, then E steps 31→32→…→36; 10 steps; done.
- Masked start: Q[1][*]=0; start 1, goal 36 -> no step_valid; fail pulses 2 cycles after start; step_count=0.
- Loop: Q[1][0]=9, Q[7][2]=9, all others 1; start 1, goal 36 -> walk oscillates 1↔7; fail after exactly MAX_STEPS=36 accepted steps.
- Backpressure and reset: hold step_ready=0 for 5 cycles on the first step -> outputs stable and step_count unchanged; then drive rst=0 during EMIT -> all outputs 0 on the next edge, FSM in IDLE.

Source files
------------

// File: rtl/q_path_follower.sv
// Greedy path follower for the 6x6 grid Q-learner.
// Starting from a given cell, it repeatedly takes the highest-valued legal,
// unmasked action and streams each step out over a valid/ready handshake.
// The walk ends with a one-cycle done pulse at the goal, or a one-cycle
// fail pulse when no move is possible or the step budget is exhausted.
module q_path_follower #(
    parameter int Q_W       = 32,
    parameter int MAX_STEPS = 36
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [Q_W-1:0] q_table [0:36][0:3],
    input  logic [5:0]     start_state,
    input  logic [5:0]     goal_state,
    input  logic           start,
    input  logic           step_ready,
    output logic           step_valid,
    output logic [5:0]     step_state,
    output logic [1:0]     step_dir,
    output logic [5:0]     step_next,
    output logic [7:0]     step_count,
    output logic           busy,
    output logic           done,
    output logic           fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_EMIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state, state_nxt;

    logic [5:0]     cur;
    logic [5:0]     goal;
    logic           cur_ok;
    logic           goal_ok;
    logic [5:0]     q_idx;
    logic [Q_W-1:0] qv [0:3];
    logic [3:0]     legal;
    logic           found;
    logic [1:0]     best_dir;
    logic [Q_W-1:0] best_q;
    logic           load_step;
    logic           accept;

    // Cell number lies inside the 6x6 grid.
    function automatic logic cell_in_grid(input logic [5:0] s);
        return (s >= 6'd1) && (s <= 6'd36);
    endfunction

    // Bit a is set when action a keeps the walk on the grid (N, E, S, W).
    function automatic logic [3:0] legal_actions(input logic [5:0] s);
        logic [3:0] m;
        m[0] = (s <= 6'd30);
        m[1] = ((s % 6'd6) != 6'd0);
        m[2] = (s >= 6'd7);
        m[3] = ((s % 6'd6) != 6'd1);
        return m;
    endfunction

    // Destination cell of action dir from cell s.
    function automatic logic [5:0] move_cell(input logic [5:0] s, input logic [1:0] dir);
        logic [5:0] n;
        case (dir)
            2'd0:    n = s + 6'd6;
            2'd1:    n = s + 6'd1;
            2'd2:    n = s - 6'd6;
            default: n = s - 6'd1;
        endcase
        return n;
    endfunction

    assign cur_ok  = cell_in_grid(cur);
    assign goal_ok = cell_in_grid(goal);
    // Out-of-grid cells read row 0 so the table is never indexed past its end.
    assign q_idx   = cur_ok ? cur : 6'd0;
    assign legal   = legal_actions(cur);

    // Pick the largest unmasked legal Q; strict compare keeps the lowest index on ties.
    always_comb begin
        found    = 1'b0;
        best_dir = 2'd0;
        best_q   = '0;
        for (int a = 0; a < 4; a++) begin
            qv[a] = q_table[q_idx][a];
            if (legal[a] && (qv[a] != '0) && (!found || (qv[a] > best_q))) begin
                found    = 1'b1;
                best_dir = 2'(a);
                best_q   = qv[a];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and step load/accept strobes.
    always_comb begin
        state_nxt = state;
        load_step = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (!cur_ok || !goal_ok) begin
                    state_nxt = S_FAIL;
                end else if (cur == goal) begin
                    state_nxt = S_DONE;
                end else if (step_count == 8'(MAX_STEPS)) begin
                    state_nxt = S_FAIL;
                end else if (!found) begin
                    state_nxt = S_FAIL;
                end else begin
                    load_step = 1'b1;
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (step_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_EVAL;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Walk position, presented step and step counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur        <= 6'd0;
            goal       <= 6'd0;
            step_state <= 6'd0;
            step_dir   <= 2'd0;
            step_next  <= 6'd0;
            step_count <= 8'd0;
        end else begin
            if ((state == S_IDLE) && start) begin
                cur        <= start_state;
                goal       <= goal_state;
                step_count <= 8'd0;
            end
            if (load_step) begin
                step_state <= cur;
                step_dir   <= best_dir;
                step_next  <= move_cell(cur, best_dir);
            end
            if (accept) begin
                cur <= step_next;
                if (step_count != 8'd255) begin
                    step_count <= step_count + 8'd1;
                end
            end
        end
    end

    assign step_valid = (state == S_EMIT);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign fail       = (state == S_FAIL);

endmodule

// File: tb/tb_q_path_follower.sv
// Scoreboard bench for q_path_follower: a grid-level reference walk fills
// expected-step and expected-outcome queues; a monitor compares the DUT.
module tb_q_path_follower;

    localparam int MAXS = 36;

    logic        clk;
    logic        rst;
    logic [31:0] q [0:36][0:3];
    logic [5:0]  start_state;
    logic [5:0]  goal_state;
    logic        start;
    logic        step_ready;
    logic        step_valid;
    logic [5:0]  step_state;
    logic [1:0]  step_dir;
    logic [5:0]  step_next;
    logic [7:0]  step_count;
    logic        busy;
    logic        done;
    logic        fail;

    typedef struct packed {
        logic [5:0] s;
        logic [1:0] d;
        logic [5:0] n;
    } step_t;

    typedef struct packed {
        logic       ok;
        logic [7:0] cnt;
    } end_t;

    step_t exp_steps[$];
    end_t  exp_end[$];

    int n_total = 0;
    int n_pass  = 0;

    logic rdy_rand = 1'b1;
    logic rdy_hold = 1'b1;

    q_path_follower #(.Q_W(32), .MAX_STEPS(MAXS)) dut (
        .clk(clk),
        .rst(rst),
        .q_table(q),
        .start_state(start_state),
        .goal_state(goal_state),
        .start(start),
        .step_ready(step_ready),
        .step_valid(step_valid),
        .step_state(step_state),
        .step_dir(step_dir),
        .step_next(step_next),
        .step_count(step_count),
        .busy(busy),
        .done(done),
        .fail(fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference walk on the grid using row/column geometry.
    function automatic void model_walk(input int s, input int g);
        int    cur;
        int    n;
        int    row;
        int    col;
        int    best;
        int    nb [4];
        bit    ok [4];
        step_t st;
        end_t  en;
        cur = s;
        n   = 0;
        if (s < 1 || s > 36 || g < 1 || g > 36) begin
            en.ok = 1'b0; en.cnt = 8'd0;
            exp_end.push_back(en);
            return;
        end
        while (1) begin
            if (cur == g) begin
                en.ok = 1'b1; en.cnt = 8'(n);
                exp_end.push_back(en);
                return;
            end
            if (n == MAXS) begin
                en.ok = 1'b0; en.cnt = 8'(n);
                exp_end.push_back(en);
                return;
            end
            row = (cur - 1) / 6;
            col = (cur - 1) % 6;
            nb[0] = cur + 6; ok[0] = (row < 5);
            nb[1] = cur + 1; ok[1] = (col < 5);
            nb[2] = cur - 6; ok[2] = (row > 0);
            nb[3] = cur - 1; ok[3] = (col > 0);
            best = -1;
            for (int a = 0; a < 4; a++) begin
                if (ok[a] && q[cur][a] != 0 && (best < 0 || q[cur][a] > q[cur][best])) begin
                    best = a;
                end
            end
            if (best < 0) begin
                en.ok = 1'b0; en.cnt = 8'(n);
                exp_end.push_back(en);
                return;
            end
            st.s = 6'(cur); st.d = 2'(best); st.n = 6'(nb[best]);
            exp_steps.push_back(st);
            cur = nb[best];
            n++;
        end
    endfunction

    task automatic fill_q(input logic [31:0] v);
        for (int s = 0; s <= 36; s++) begin
            for (int a = 0; a < 4; a++) begin
                q[s][a] = v;
            end
        end
    endtask

    // Launch a walk, wait for its end; report end latency and first-valid latency.
    task automatic run_walk(input int s, input int g, output int lat, output int fv);
        start_state = 6'(s);
        goal_state  = 6'(g);
        model_walk(s, g);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        fv  = -1;
        while (!(done || fail) && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (step_valid && fv < 0) fv = lat;
        end
        if (lat >= 2000) begin
            chk("walk_timeout", 32'(lat), 32'd0);
            exp_steps.delete();
            exp_end.delete();
        end
        @(negedge clk);
        chk("busy_falls", 32'(busy), 32'd0);
    endtask

    // Downstream ready: random or held, changed just after each rising edge.
    initial begin
        step_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            step_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
        end
    end

    // Monitor: compare every accepted step and every end pulse to the scoreboard.
    initial begin
        step_t e;
        end_t  f;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (step_valid && step_ready) begin
                    if (exp_steps.size() == 0) begin
                        chk("unexpected_step", 32'({step_state, step_dir, step_next}), 32'hffff_ffff);
                    end else begin
                        e = exp_steps.pop_front();
                        chk("step", 32'({step_state, step_dir, step_next}), 32'(e));
                    end
                end
                if (done || fail) begin
                    chk("one_pulse", 32'(done & fail), 32'd0);
                    if (exp_end.size() == 0) begin
                        chk("unexpected_end", 32'({done, fail}), 32'd0);
                    end else begin
                        f = exp_end.pop_front();
                        chk("end_kind", 32'(done), 32'(f.ok));
                        chk("end_count", 32'(step_count), 32'(f.cnt));
                        chk("steps_drained", 32'(exp_steps.size()), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    lat;
        int    fv;
        int    r;
        int    s;
        int    g;
        logic [13:0] snap;

        rst         = 1'b0;
        start       = 1'b1;
        start_state = 6'd1;
        goal_state  = 6'd36;
        fill_q(32'd1);

        // Reset held with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", 32'({step_valid, step_state, step_dir, step_next, step_count, busy, done, fail}), 32'd0);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("no_walk_after_reset", 32'({busy, step_valid}), 32'd0);

        // Simple two-step path.
        fill_q(32'd1);
        q[1][1] = 32'd5;
        q[2][0] = 32'd5;
        run_walk(1, 8, lat, fv);
        chk("first_valid_latency", 32'(fv), 32'd1);

        // All-equal table: N preferred until the top row, then E.
        fill_q(32'd7);
        run_walk(1, 36, lat, fv);

        // Masked start cell.
        fill_q(32'd1);
        q[1][0] = 0; q[1][1] = 0; q[1][2] = 0; q[1][3] = 0;
        run_walk(1, 36, lat, fv);
        chk("masked_fail_latency", 32'(lat), 32'd1);
        chk("masked_no_valid", 32'(fv), 32'hffff_ffff);

        // Oscillation 1 <-> 7 until the step budget runs out.
        fill_q(32'd1);
        q[1][0] = 32'd9;
        q[7][2] = 32'd9;
        run_walk(1, 36, lat, fv);

        // Start equals goal.
        fill_q(32'd3);
        run_walk(5, 5, lat, fv);
        chk("same_cell_done_latency", 32'(lat), 32'd1);
        chk("same_cell_count", 32'(step_count), 32'd0);

        // Goal outside the grid.
        run_walk(3, 40, lat, fv);
        chk("bad_goal_latency", 32'(lat), 32'd1);

        // Randomized tables, endpoints and backpressure.
        for (int t = 0; t < 24; t++) begin
            for (int cs = 0; cs <= 36; cs++) begin
                for (int a = 0; a < 4; a++) begin
                    r = int'($urandom_range(0, 9));
                    if (t % 4 == 3) q[cs][a] = (r < 2) ? 32'd0 : $urandom;
                    else            q[cs][a] = (r < 2) ? 32'd0 : 32'(r % 4 + 1);
                end
            end
            s = (t % 8 == 7) ? 0 : int'($urandom_range(1, 36));
            g = int'($urandom_range(1, 36));
            run_walk(s, g, lat, fv);
        end

        // Backpressure on the first step, then reset during EMIT.
        rdy_rand = 1'b0;
        rdy_hold = 1'b0;
        fill_q(32'd1);
        q[1][1] = 32'd5;
        q[2][0] = 32'd5;
        @(negedge clk);
        @(negedge clk);
        start_state = 6'd1;
        goal_state  = 6'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("bp_valid", 32'(step_valid), 32'd1);
        chk("bp_first_step", 32'({step_state, step_dir, step_next}), 32'({6'd1, 2'd1, 6'd2}));
        snap = {step_state, step_dir, step_next};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", 32'({step_valid, step_state, step_dir, step_next}), 32'({1'b1, snap}));
            chk("bp_count", 32'(step_count), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_walk_reset", 32'({step_valid, step_state, step_dir, step_next, step_count, busy, done, fail}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'({busy, step_valid, done, fail}), 32'd0);

        // Recovery walk after the reset.
        rdy_rand = 1'b1;
        run_walk(1, 8, lat, fv);
        chk("recovery_count", 32'(step_count), 32'd2);
        repeat (3) @(negedge clk);
        chk("queues_empty", 32'(exp_steps.size() + exp_end.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
